program_loader: RTL and testbench
=================================

Name: program_loader

Overview:
- Writer side of the instruction-memory interface that the pipeline's fetch stage reads as InstructionOut.
- Accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words.
- Writes each word into instruction memory at consecutive word-aligned byte addresses.
- Holds the PA_RISC core in reset with LE low while loading; releases reset and raises LE when the load completes.

Parameters:
ADDR_W, 9, instruction-memory byte-address width (memory holds 2^ADDR_W bytes)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
load_start  input  1  one-cycle pulse; starts a load; sampled only in IDLE or DONE
load_len  input  ADDR_W+1  number of bytes to load; sampled with load_start
byte_valid  input  1  byte_data is valid
byte_data  input  8  stream byte; first byte of each word is its MSB
byte_ready  output  1  loader accepts a byte this cycle
im_we  output  1  instruction-memory word write enable, one cycle per word
im_addr  output  ADDR_W  word-aligned byte address; bits [1:0] always 0
im_wdata  output  32  assembled instruction word
core_reset  output  1  active-high reset to the core
core_le  output  1  pipeline-register load enable to the core
done  output  1  load completed
err  output  1  last load_start carried an illegal length

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; byte_ready=0, im_we=0, im_addr=0, im_wdata=0.
  - core_reset=1, core_le=0, done=0, err=0.
  - Internal byte counter and shift word cleared.
- States: IDLE, RECV, WRITE, DONE (state encoding is 2 bits).
- byte_ready is 1 exactly when state==RECV. A byte transfers on a rising edge where byte_valid and byte_ready are both 1.
- IDLE, or DONE, when load_start=1:
  - Illegal length: load_len==0, load_len[1:0]!=0, or load_len > 2^ADDR_W.
    - Illegal: err<=1; go to or stay in IDLE; core outputs unchanged.
  - Legal:
    - err<=0, done<=0.
    - core_reset<=1, core_le<=0.
    - Latch load_len; byte count<=0; im_addr<=0; go to RECV.
- RECV, on each transfer:
  - word <= {word[23:0], byte_data}; count+1.
  - On the transfer that makes count%4==0, go to WRITE.
- Partial words: stalls (byte_valid=0) are unbounded, and a partially assembled word is held indefinitely.
- WRITE (exactly one cycle):
  - im_we=1, im_wdata=word, im_addr=current word address.
  - Next edge: im_addr += 4.
  - If count==latched len, go to DONE; else return to RECV.
- Latency:
  - 4th byte of a word transfers at edge N.
  - im_we is high during cycle N..N+1; byte_ready is low in that same cycle.
  - byte_ready is high again from edge N+1.
  - Throughput is 4 bytes per 5 cycles at best.
- DONE:
  - done=1, core_reset=0, core_le=1; byte_ready=0.
  - Held until reset or a new legal load_start.
- Address wrap: a full-size load (len=2^ADDR_W) ends with a last write at 2^ADDR_W-4. The post-increment wraps im_addr to 0, which is harmless because no further write follows.
- load_start in RECV or WRITE is ignored; err is unchanged.
- Outputs in a new legal load: im_we stays 0 until the first word completes, and stale im_wdata is never written.
- Reset mid-load (asserted in any state):
  - Immediately returns to the reset values; core_reset=1 and core_le=0 at once.
  - Bytes already written stay in memory, and the partial word is discarded.

Decomposition:
- Shared package: loader state encoding constants (IDLE, RECV, WRITE, DONE) and the constant WORD_BYTES=4.
- One natural sub-module: word_assembler, which holds the byte shift register plus the 2-bit byte-in-word counter and issues the word_full strobe.
- FSM, address counter, and core-control outputs live in program_loader.

Test Plan:
1. Reset and idle: reset=0 then 1, no stimulus → core_reset=1, core_le=0, byte_ready=0, im_we=0, done=0, err=0.
2. Single word: load_len=4, bytes 0x08,0x00,0x06,0x00 with byte_valid continuously high → one im_we pulse with im_addr=0, im_wdata=0x08000600, then done=1, core_reset=0, core_le=1.
3. Three words with random byte_valid gaps: load_len=12 → exactly three im_we pulses at addresses 0, 4, 8 with correct words, and byte_ready=0 during each write cycle.
4. Illegal lengths:
   - load_len=6, 0, or 2^ADDR_W+4 → err=1, state IDLE, no im_we, core_reset stays 1.
   - A following legal load_len=4 clears err.
5. Reset mid-word: after 2 bytes of the second word, pulse reset=0 → all outputs return to reset values at once; no im_we for the partial word; a new load starts writing at address 0.
6. Reload from DONE: after a completed load, load_start with load_len=8 → core_reset returns to 1 and core_le to 0 the next cycle; writes at 0 and 4; done is reasserted.

Source files
------------

// File: rtl/program_loader_pkg.sv
// Shared definitions for the instruction-memory program loader:
// loader state encoding and instruction word geometry.
package program_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int WORD_BYTES = 4;

endpackage

// File: rtl/program_loader_word_assembler.sv
// Shifts stream bytes into a big-endian 32-bit word and strobes word_full
// on the byte that completes the word.
module program_loader_word_assembler
  import program_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        shift_en,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        word_full
);

  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] word_q, word_d;

  always_comb begin
    cnt_d  = cnt_q;
    word_d = word_q;
    if (clear) begin
      cnt_d  = 2'd0;
      word_d = 32'd0;
    end else if (shift_en) begin
      // First byte of a word ends up in the MSB after four shifts.
      word_d = {word_q[23:0], byte_data};
      cnt_d  = cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= 2'd0;
      word_q <= 32'd0;
    end else begin
      cnt_q  <= cnt_d;
      word_q <= word_d;
    end
  end

  assign word      = word_q;
  assign word_full = shift_en && (cnt_q == 2'(WORD_BYTES - 1));

endmodule

// File: rtl/program_loader.sv
// Loads a byte stream into instruction memory as big-endian words while
// holding the core in reset; releases the core once the load completes.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic [ADDR_W:0]   load_len,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              core_reset,
  output logic              core_le,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

  state_t            state_q, state_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              done_q, done_d;
  logic              core_reset_q, core_reset_d;
  logic              core_le_q, core_le_d;
  logic              err_q, err_d;

  logic        xfer;
  logic        len_ok;
  logic        asm_clear;
  logic        word_full;
  logic [31:0] word;

  assign xfer   = byte_valid && (state_q == RECV);
  assign len_ok = (load_len != '0) && (load_len[1:0] == 2'b00) && (load_len <= MAX_LEN);

  program_loader_word_assembler u_word_assembler (
    .clk       (clk),
    .reset     (reset),
    .clear     (asm_clear),
    .shift_en  (xfer),
    .byte_data (byte_data),
    .word      (word),
    .word_full (word_full)
  );

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    count_d      = count_q;
    addr_d       = addr_q;
    done_d       = done_q;
    core_reset_d = core_reset_q;
    core_le_d    = core_le_q;
    err_d        = err_q;
    asm_clear    = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (load_start) begin
          if (!len_ok) begin
            // Rejected loads leave the core outputs exactly as they were.
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            err_d        = 1'b0;
            done_d       = 1'b0;
            core_reset_d = 1'b1;
            core_le_d    = 1'b0;
            len_d        = load_len;
            count_d      = '0;
            addr_d       = '0;
            asm_clear    = 1'b1;
            state_d      = RECV;
          end
        end
      end
      RECV: begin
        if (xfer) begin
          count_d = count_q + (ADDR_W + 1)'(1);
          if (word_full) state_d = WRITE;
        end
      end
      WRITE: begin
        // A full-size load wraps the address to 0 here; nothing is written after it.
        addr_d = addr_q + ADDR_W'(WORD_BYTES);
        if (count_q == len_q) begin
          state_d      = DONE;
          done_d       = 1'b1;
          core_reset_d = 1'b0;
          core_le_d    = 1'b1;
        end else begin
          state_d = RECV;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      len_q        <= '0;
      count_q      <= '0;
      addr_q       <= '0;
      done_q       <= 1'b0;
      core_reset_q <= 1'b1;
      core_le_q    <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      count_q      <= count_d;
      addr_q       <= addr_d;
      done_q       <= done_d;
      core_reset_q <= core_reset_d;
      core_le_q    <= core_le_d;
      err_q        <= err_d;
    end
  end

  assign byte_ready = (state_q == RECV);
  assign im_we      = (state_q == WRITE);
  assign im_addr    = addr_q;
  assign im_wdata   = word;
  assign core_reset = core_reset_q;
  assign core_le    = core_le_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: table of load vectors plus hand-written
// reset-mid-load and reload sequences.
module tb_program_loader;

  localparam int ADDR_W = 9;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              load_start = 1'b0;
  logic [ADDR_W:0]   load_len = '0;
  logic              byte_valid = 1'b0;
  logic [7:0]        byte_data = 8'd0;
  logic              byte_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;
  logic              core_reset;
  logic              core_le;
  logic              done;
  logic              err;

  program_loader #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_start (load_start),
    .load_len   (load_len),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .im_we      (im_we),
    .im_addr    (im_addr),
    .im_wdata   (im_wdata),
    .core_reset (core_reset),
    .core_le    (core_le),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0]        tx_bytes[$];
  logic [ADDR_W-1:0] wr_addr[$];
  logic [31:0]       wr_data[$];
  int                ready_bad = 0;

  // Write monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (reset && im_we) begin
      wr_addr.push_back(im_addr);
      wr_data.push_back(im_wdata);
      if (byte_ready) ready_bad++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic build_bytes(input int t, input int len, input logic [31:0] w0);
    tx_bytes.delete();
    for (int i = 0; i < len; i++) begin
      if (i < 4) tx_bytes.push_back(w0[31 - 8*i -: 8]);
      else       tx_bytes.push_back(8'(i * 29 + t * 7));
    end
  endtask

  task automatic send_bytes(input int n, input bit gaps);
    int idx = 0;
    int budget = 20 * n + 50;
    while (idx < n && budget > 0) begin
      @(negedge clk);
      budget--;
      if (gaps && $urandom_range(0, 2) == 0) begin
        byte_valid = 1'b0;
      end else begin
        byte_valid = 1'b1;
        byte_data  = tx_bytes[idx];
        // byte_ready only changes on a rising edge, so this value holds at the next edge.
        if (byte_ready) idx++;
      end
    end
    @(negedge clk);
    byte_valid = 1'b0;
    if (idx < n) check("send_timeout", 32'(idx), 32'(n));
  endtask

  task automatic pulse_start(input logic [ADDR_W:0] len);
    @(negedge clk);
    load_start = 1'b1;
    load_len   = len;
    @(negedge clk);
    load_start = 1'b0;
  endtask

  task automatic run_load(input int t, input logic [ADDR_W:0] len, input bit gaps,
                          input bit exp_err, input logic [31:0] w0);
    int w;
    int nw;
    logic [31:0] exp_w;
    build_bytes(t, int'(len), w0);
    wr_addr.delete();
    wr_data.delete();
    ready_bad = 0;
    pulse_start(len);
    check($sformatf("v%0d_err", t), 32'(err), 32'(exp_err));
    if (exp_err) begin
      check($sformatf("v%0d_core_reset", t), 32'(core_reset), 32'd1);
      check($sformatf("v%0d_ready_idle", t), 32'(byte_ready), 32'd0);
      check($sformatf("v%0d_done", t), 32'(done), 32'd0);
      repeat (4) @(negedge clk);
      check($sformatf("v%0d_no_write", t), 32'(wr_addr.size()), 32'd0);
      $display("vector %0d: len=%0d rejected, err=%0d", t, len, err);
      return;
    end
    check($sformatf("v%0d_start_core_reset", t), 32'(core_reset), 32'd1);
    check($sformatf("v%0d_start_core_le", t), 32'(core_le), 32'd0);
    check($sformatf("v%0d_start_done", t), 32'(done), 32'd0);
    check($sformatf("v%0d_start_ready", t), 32'(byte_ready), 32'd1);
    send_bytes(int'(len), gaps);
    w = 0;
    while (done !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    nw = int'(len) / 4;
    check($sformatf("v%0d_done", t), 32'(done), 32'd1);
    check($sformatf("v%0d_core_reset", t), 32'(core_reset), 32'd0);
    check($sformatf("v%0d_core_le", t), 32'(core_le), 32'd1);
    check($sformatf("v%0d_ready_done", t), 32'(byte_ready), 32'd0);
    check($sformatf("v%0d_nwrites", t), 32'(wr_addr.size()), 32'(nw));
    check($sformatf("v%0d_ready_in_write", t), 32'(ready_bad), 32'd0);
    for (int k = 0; k < nw && k < wr_addr.size(); k++) begin
      exp_w = {tx_bytes[4*k], tx_bytes[4*k+1], tx_bytes[4*k+2], tx_bytes[4*k+3]};
      check($sformatf("v%0d_addr%0d", t, k), 32'(wr_addr[k]), 32'((4 * k) % (1 << ADDR_W)));
      check($sformatf("v%0d_data%0d", t, k), wr_data[k], exp_w);
    end
    $display("vector %0d: len=%0d gaps=%0d writes=%0d done=%0d", t, len, gaps, wr_addr.size(), done);
  endtask

  typedef struct {
    logic [ADDR_W:0] len;
    bit              gaps;
    bit              exp_err;
    logic [31:0]     w0;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{len: 10'd6,   gaps: 1'b0, exp_err: 1'b1, w0: 32'h0};
    vecs[1] = '{len: 10'd0,   gaps: 1'b0, exp_err: 1'b1, w0: 32'h0};
    vecs[2] = '{len: 10'd516, gaps: 1'b0, exp_err: 1'b1, w0: 32'h0};
    vecs[3] = '{len: 10'd4,   gaps: 1'b0, exp_err: 1'b0, w0: 32'h08000600};
    vecs[4] = '{len: 10'd12,  gaps: 1'b1, exp_err: 1'b0, w0: 32'hdeadbeef};
    vecs[5] = '{len: 10'd8,   gaps: 1'b0, exp_err: 1'b0, w0: 32'h12345678};
    vecs[6] = '{len: 10'd512, gaps: 1'b0, exp_err: 1'b0, w0: 32'ha5c3e1f0};

    // Reset and idle.
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_core_reset", 32'(core_reset), 32'd1);
    check("rst_core_le", 32'(core_le), 32'd0);
    check("rst_byte_ready", 32'(byte_ready), 32'd0);
    check("rst_im_we", 32'(im_we), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_im_addr", 32'(im_addr), 32'd0);
    $display("reset: core_reset=%0d core_le=%0d done=%0d err=%0d", core_reset, core_le, done, err);

    for (int t = 0; t < 7; t++)
      run_load(t, vecs[t].len, vecs[t].gaps, vecs[t].exp_err, vecs[t].w0);

    // Reset mid-word: first word written, two bytes of the second in flight.
    build_bytes(10, 8, 32'hcafef00d);
    wr_addr.delete();
    wr_data.delete();
    pulse_start(10'd8);
    send_bytes(6, 1'b0);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("mid_core_reset", 32'(core_reset), 32'd1);
    check("mid_core_le", 32'(core_le), 32'd0);
    check("mid_byte_ready", 32'(byte_ready), 32'd0);
    check("mid_im_we", 32'(im_we), 32'd0);
    check("mid_done", 32'(done), 32'd0);
    check("mid_im_addr", 32'(im_addr), 32'd0);
    check("mid_im_wdata", im_wdata, 32'd0);
    check("mid_nwrites", 32'(wr_addr.size()), 32'd1);
    if (wr_data.size() > 0) check("mid_word0", wr_data[0], 32'hcafef00d);
    $display("reset mid-load: writes before reset=%0d", wr_addr.size());
    @(negedge clk);
    reset = 1'b1;
    run_load(11, 10'd4, 1'b1, 1'b0, 32'h01020304);

    // Reload from DONE after the previous completed load.
    run_load(12, 10'd8, 1'b1, 1'b0, 32'h89abcdef);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
